// File: rtl/mips_ctrl_pkg.sv
// Opcode/control constants shared by the instruction loader and the core's control decoder,
// so the producer and consumer of the opcode interface always agree.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        CLS_R   = 2'b00,
        CLS_LW  = 2'b01,
        CLS_SW  = 2'b10,
        CLS_BEQ = 2'b11
    } cls_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    typedef struct packed {
        cls_t        cls;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
    } fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction class plus operand fields -> 32-bit MIPS word.
// Fields that a class does not use (rd/funct for I-type, imm for R-type) are ignored.
module instr_pack
    import mips_ctrl_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (f.cls)
            CLS_R:   word = {OP_RTYPE, f.rs, f.rt, f.rd, 5'b00000, f.funct};
            CLS_LW:  word = {OP_LW,  f.rs, f.rt, f.imm};
            CLS_SW:  word = {OP_SW,  f.rs, f.rt, f.imm};
            CLS_BEQ: word = {OP_BEQ, f.rs, f.rt, f.imm};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts one decoded instruction bundle at a time, encodes it and writes it
// into instruction memory at a running address. Define CHECKSUM_EN to add the csum output.
//
// Handshake: a bundle transfers on a rising edge where in_valid && in_ready; in_ready is high
// only in IDLE outside reset/clear, and in_valid while in_ready=0 is ignored (fields may change).
module instr_encoder_loader
    import mips_ctrl_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   count,
`ifdef CHECKSUM_EN
    output logic [31:0]       csum,
`endif
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, state_next;
    fields_t           hold;
    logic              hold_last;
    logic [ADDR_W-1:0] addr;
    logic              xfer;
    fields_t           in_f;

    assign in_f = '{cls: cls_t'(in_class), rs: in_rs, rt: in_rt, rd: in_rd,
                    funct: in_funct, imm: in_imm};

    instr_pack u_pack (
        .f    (hold),
        .word (imem_wdata)
    );

    // reset/clear during WRITE suppresses the strobe so the pending bundle is dropped
    assign in_ready  = (state == ST_IDLE)  && !reset && !clear;
    assign imem_we   = (state == ST_WRITE) && !reset && !clear;
    assign xfer      = in_valid && in_ready;
    assign imem_addr = addr;
    assign done      = (state == ST_DONE);
    assign full      = (state == ST_FULL);
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (xfer) state_next = ST_WRITE;
            ST_WRITE: begin
                if (hold_last)
                    state_next = ST_DONE;
                else if (addr == LAST_ADDR)
                    state_next = ST_FULL;
                else
                    state_next = ST_IDLE;
            end
            default:  state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= ST_IDLE;
            hold      <= '0;
            hold_last <= 1'b0;
            addr      <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            if (xfer) begin
                hold      <= in_f;
                hold_last <= in_last;
            end
            // the top address is the final slot; it never wraps back to 0
            if (imem_we) begin
                count <= count + (ADDR_W+1)'(1);
                if (addr != LAST_ADDR)
                    addr <= addr + ADDR_W'(1);
            end
            // err: a bundle was offered after the program had already ended (DONE or FULL)
            if (in_valid && (state == ST_DONE || state == ST_FULL))
                err <= 1'b1;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || clear)
            csum <= '0;
        else if (imem_we)
            csum <= csum ^ imem_wdata;
    end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (ADDR_W=2 so the full boundary is reachable quickly).
// A write monitor compares every imem_we against an expected queue of {addr, word}.
module tb_instr_encoder_loader;
  import mips_ctrl_pkg::*;

  localparam int AW = 2;
  localparam int QW = AW + 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [1:0]    in_class = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]    in_funct = '0;
  logic [15:0]   in_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done, full, err;
  logic [AW:0]   count;
  logic [1:0]    dbg_state;
`ifdef CHECKSUM_EN
  logic [31:0]   csum;
`endif

  int total = 0;
  int bad = 0;
  logic [QW-1:0] exp_q[$];
  logic [AW-1:0] model_addr = '0;
  int            model_count = 0;
  logic [31:0]   model_csum = '0;

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_class   (in_class),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_funct   (in_funct),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .done       (done),
    .full       (full),
    .count      (count),
`ifdef CHECKSUM_EN
    .csum       (csum),
`endif
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: sampled mid-low-phase, well away from the rising edge
  always @(negedge clk) begin
    #3;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {imem_addr, imem_wdata}, '0);
      end else begin
        logic [QW-1:0] e;
        e = exp_q.pop_front();
        check("write", {imem_addr, imem_wdata}, e);
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_addr = '0; model_count = 0; model_csum = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_addr = '0; model_count = 0; model_csum = '0;
    @(negedge clk);
    check("clr_ready", in_ready, 1);
    check("clr_addr", imem_addr, 0);
    check("clr_count", count, 0);
    check("clr_done", done, 0);
    check("clr_full", full, 0);
    check("clr_err", err, 0);
`ifdef CHECKSUM_EN
    check("clr_csum", csum, 0);
`endif
  endtask

  // driver: one bundle, with in_valid held and fields scrambled through the WRITE cycle
  task automatic send(input logic [1:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                      input logic last, input logic [31:0] exp_word);
    check("ready_idle", in_ready, 1);
    in_valid = 1'b1; in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = funct; in_imm = imm; in_last = last;
    exp_q.push_back({model_addr, exp_word});
    @(negedge clk);
    check("ready_write", in_ready, 0);
    check("done_early", done, 0);
    check("full_early", full, 0);
    in_class = 2'($urandom_range(0, 3)); in_rs = 5'($urandom_range(0, 31));
    in_rt = 5'($urandom_range(0, 31)); in_imm = 16'($urandom_range(0, 65535));
    in_last = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    model_count++;
    model_csum = model_csum ^ exp_word;
    if (model_addr != AW'(3)) model_addr = model_addr + 1'b1;
    check("count", count, model_count);
`ifdef CHECKSUM_EN
    check("csum", csum, model_csum);
`endif
  endtask

  task automatic poke_ignored(input string tag);
    in_valid = 1'b1; in_class = 2'b01; in_imm = 16'h5555;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_count"}, count, model_count);
    check({tag, "_err"}, err, 1);
  endtask

  initial begin
    // reset held two cycles
    do_reset(0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);
`ifdef CHECKSUM_EN
    check("rst_csum", csum, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready", in_ready, 1);
    check("rel_state", dbg_state, ST_IDLE);

    // R-type add $3,$1,$2 (imm garbage must be ignored)
    send(CLS_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF, 1'b0, 32'h00221820);
    check("r_addr_next", imem_addr, 1);

    // LW/SW/BEQ at 0..2, third one last (rd/funct garbage must be ignored)
    do_clear();
    send(CLS_LW, 5'd0, 5'd8, 5'h1F, 6'h3F, 16'h0004, 1'b0, 32'h8C080004);
    send(CLS_SW, 5'd0, 5'd8, 5'd0, 6'h00, 16'h0004, 1'b0, 32'hAC080004);
    send(CLS_BEQ, 5'd1, 5'd2, 5'd7, 6'h11, 16'hFFFF, 1'b1, 32'h1022FFFF);
    check("last_count", count, 3);
    check("last_done", done, 1);
    check("last_full", full, 0);
    check("last_ready", in_ready, 0);
    check("last_state", dbg_state, ST_DONE);
`ifdef CHECKSUM_EN
    check("last_csum", csum, 32'h3022FFFF);
`endif
    poke_ignored("after_done");
    check("after_done_hold", done, 1);

    // fill all four slots without in_last
    do_clear();
    send(CLS_R, 5'd31, 5'd0, 5'd31, 6'h2A, 16'h0000, 1'b0, 32'h03E0F82A);
    send(CLS_LW, 5'd31, 5'd31, 5'd0, 6'h00, 16'h8000, 1'b0, 32'h8FFF8000);
    send(CLS_SW, 5'd2, 5'd3, 5'd0, 6'h00, 16'h1234, 1'b0, 32'hAC431234);
    send(CLS_BEQ, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 1'b0, 32'h10000000);
    check("full_flag", full, 1);
    check("full_done", done, 0);
    check("full_addr", imem_addr, 3);
    check("full_count", count, 4);
    poke_ignored("after_full");

    // last lands on the top address: DONE wins over FULL
    do_clear();
    send(CLS_R, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0000, 1'b0, 32'h00853022);
    send(CLS_R, 5'd4, 5'd5, 5'd6, 6'h24, 16'h0000, 1'b0, 32'h00853024);
    send(CLS_R, 5'd4, 5'd5, 5'd6, 6'h25, 16'h0000, 1'b0, 32'h00853025);
    send(CLS_LW, 5'd29, 5'd31, 5'd0, 6'h00, 16'h0010, 1'b1, 32'h8FBF0010);
    check("edge_done", done, 1);
    check("edge_full", full, 0);
    check("edge_addr", imem_addr, 3);

    // reset asserted in the WRITE cycle drops the bundle
    do_clear();
    send(CLS_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 1'b0, 32'h00221820);
    send(CLS_LW, 5'd0, 5'd8, 5'd0, 6'h00, 16'h0004, 1'b0, 32'h8C080004);
`ifdef CHECKSUM_EN
    check("mid_csum", csum, 32'h8C2A1824);
`endif
    in_valid = 1'b1; in_class = CLS_SW; in_rs = 5'd0; in_rt = 5'd8; in_imm = 16'h0004;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_we", imem_we, 0);
    check("mid_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    model_addr = '0; model_count = 0; model_csum = '0;
    check("mid_count", count, 0);
    check("mid_addr", imem_addr, 0);
    check("mid_wdata", imem_wdata, 0);
`ifdef CHECKSUM_EN
    check("mid_csum_rst", csum, 0);
`endif
    @(negedge clk);
    check("mid_ready_after", in_ready, 1);
    check("mid_count_after", count, 0);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
